rr_arb8: RTL and testbench

- Eight-requester round-robin arbiter with packet locking that shares one N-bit datapath.
- Each requester has a valid/ready/last stream. The block selects a winner, steers its data through an internal mux8 instance via the 3-bit select, and registers the beat into a single output stage with a valid/ready handshake.
- Sits in front of any shared single-port consumer, such as a bus or write port.

---
 rtl/rr_arb8_if.sv | 26 ++
 rtl/rr_arb8.sv | 134 +++++++++++++
 tb/tb_rr_arb8.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb8_if.sv
// Requester-side streams and the registered output stage of the eight-way arbiter.
// The arbiter uses slave; the requesters plus the consumer use master.
interface rr_arb8_if #(
  parameter int N = 32
);
  logic [8*N-1:0] in_data;
  logic [7:0]     in_valid;
  logic [7:0]     in_last;
  logic [7:0]     in_ready;
  logic [2:0]     sel;
  logic [N-1:0]   out_data;
  logic [2:0]     out_src;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, sel, out_data, out_src, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, sel, out_data, out_src, out_last, out_valid
  );
endinterface

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with packet locking, feeding one registered output stage.
// mux8 steers the selected requester's data slice onto the shared datapath.
module mux8 #(
  parameter int N = 32
) (
  input  logic [8*N-1:0] i_data,
  input  logic [2:0]     i_sel,
  output logic [N-1:0]   o_data
);
  always_comb begin
    o_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_sel == 3'(i)) o_data = i_data[i*N +: N];
    end
  end
endmodule

// state    | meaning
// S_IDLE   | rotating search from r_prio picks the winner
// S_LOCKED | only r_owner may transfer until it sends its last beat
module rr_arb8 #(
  parameter int N = 32
) (
  input  logic      clk,
  input  logic      rst,
  rr_arb8_if.slave  bus
);
  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_prio;
  logic [2:0]   w_prio_nxt;
  logic [2:0]   r_owner;
  logic [2:0]   w_owner_nxt;
  logic [N-1:0] r_out_data;
  logic [2:0]   r_out_src;
  logic         r_out_last;
  logic         r_out_valid;

  logic [7:0]   w_rot;
  logic [2:0]   w_off;
  logic         w_any;
  logic [2:0]   w_idle_win;
  logic [2:0]   w_sel;
  logic         w_has;
  logic         w_free;
  logic         w_xfer;
  logic [N-1:0] w_mux_data;

  // Rotate requests so r_prio sits at bit 0, find the first set bit, rotate back.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < 8; k++) begin
      w_rot[k] = bus.in_valid[3'(k) + r_prio];
    end
    w_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
    w_any      = |bus.in_valid;
    w_idle_win = r_prio + w_off;
  end

  assign w_free = ~r_out_valid | bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_owner;
    w_sel       = r_prio;
    w_has       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_has = w_any;
        w_sel = w_any ? w_idle_win : r_prio;
      end
      S_LOCKED: begin
        w_has = bus.in_valid[r_owner];
        w_sel = r_owner;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_xfer = w_has & w_free & ~rst;
    if (w_xfer) begin
      if (bus.in_last[w_sel]) begin
        w_state_nxt = S_IDLE;
        w_prio_nxt  = w_sel + 3'd1;
      end else begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_sel;
      end
    end
  end

  mux8 #(.N(N)) u_mux8 (
    .i_data (bus.in_data),
    .i_sel  (w_sel),
    .o_data (w_mux_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prio      <= '0;
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_owner <= w_owner_nxt;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_sel;
        r_out_last  <= bus.in_last[w_sel];
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_xfer ? (8'b1 << w_sel) : 8'b0;
  assign bus.sel       = w_sel;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_rr_arb8.sv
// Table-driven directed vectors, hand-written corner sequences, and a randomized run
// against a queue-free behavioural model of the round-robin/lock rules.
module tb_rr_arb8;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arb8_if #(.N(N)) bus();
  rr_arb8 #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [7:0] vld;
    logic [7:0] lst;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_src;
    logic       exp_last;
  } vec_t;

  vec_t tbl[$];

  // model state
  int   m_prio, m_owner, m_src;
  bit   m_locked, m_ov, m_last;
  logic [N-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic [7:0] v, logic [7:0] l, logic o,
                              logic [7:0] er, logic eo, logic [2:0] es, logic el);
    vec_t t;
    t.rst = r; t.vld = v; t.lst = l; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eo; t.exp_src = es; t.exp_last = el;
    return t;
  endfunction

  function automatic logic [N-1:0] base(int i);
    return 32'hA5A5_0000 + N'(i);
  endfunction

  task automatic set_base_data();
    for (int i = 0; i < 8; i++) bus.in_data[i*N +: N] = base(i);
  endtask

  task automatic drive(input logic r, input logic [7:0] v, input logic [7:0] l, input logic o);
    rst = r; bus.in_valid = v; bus.in_last = l; bus.out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mwin(logic [7:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int j = 0; j < 8; j++) begin
      if (v[(m_prio + j) % 8]) return (m_prio + j) % 8;
    end
    return -1;
  endfunction

  initial begin
    set_base_data();
    // Test 1: reset then single requester, then show prio moved to 3
    tbl.push_back(mk(1, 8'h04, 8'h04, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 8'h04, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h04, 8'h04, 1, 8'h04, 1, 2, 1));
    tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 8'h08, 1, 3, 1));
    // Test 2: fairness from reset
    tbl.push_back(mk(1, 8'hFF, 8'hFF, 1, 8'h00, 0, 0, 0));
    for (int g = 0; g < 10; g++)
      tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 8'(1 << (g % 8)), 1, 3'(g % 8), 1));
    // Test 3: wrap-around (prio 2 -> grant 6 -> prio 7)
    tbl.push_back(mk(0, 8'h40, 8'h40, 1, 8'h40, 1, 6, 1));
    tbl.push_back(mk(0, 8'h81, 8'h81, 1, 8'h80, 1, 7, 1));
    tbl.push_back(mk(0, 8'h81, 8'h81, 1, 8'h01, 1, 0, 1));
    // Test 4: packet lock on requester 1 with a bubble, then requester 0
    tbl.push_back(mk(0, 8'h03, 8'h01, 1, 8'h02, 1, 1, 0));
    tbl.push_back(mk(0, 8'h03, 8'h01, 1, 8'h02, 1, 1, 0));
    tbl.push_back(mk(0, 8'h01, 8'h01, 1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 8'h03, 8'h03, 1, 8'h02, 1, 1, 1));
    tbl.push_back(mk(0, 8'h01, 8'h01, 1, 8'h01, 1, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].lst, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        chk($sformatf("tbl%0d_out_src", i), 64'(bus.out_src), 64'(tbl[i].exp_src));
        chk($sformatf("tbl%0d_out_last", i), 64'(bus.out_last), 64'(tbl[i].exp_last));
        chk($sformatf("tbl%0d_out_data", i), 64'(bus.out_data), 64'(base(tbl[i].exp_src)));
      end
      @(negedge clk);
    end

    // Test 5: backpressure on requester 4 (prio is 1 here)
    bus.in_data[4*N +: N] = 32'h0000_4444;
    drive(0, 8'h10, 8'h10, 1);
    chk("bp_first_rdy", 64'(bus.in_ready), 64'h10);
    tick();
    chk("bp_first_data", 64'(bus.out_data), 64'h4444);
    @(negedge clk);
    bus.in_data[4*N +: N] = 32'h0000_5555;
    for (int c = 0; c < 3; c++) begin
      drive(0, 8'h10, 8'h10, 0);
      chk($sformatf("bp_hold%0d_rdy", c), 64'(bus.in_ready), 64'h00);
      tick();
      chk($sformatf("bp_hold%0d_valid", c), 64'(bus.out_valid), 64'h1);
      chk($sformatf("bp_hold%0d_data", c), 64'(bus.out_data), 64'h4444);
      chk($sformatf("bp_hold%0d_src", c), 64'(bus.out_src), 64'h4);
      chk($sformatf("bp_hold%0d_last", c), 64'(bus.out_last), 64'h1);
      @(negedge clk);
    end
    drive(0, 8'h10, 8'h10, 1);
    chk("bp_release_rdy", 64'(bus.in_ready), 64'h10);
    tick();
    chk("bp_release_data", 64'(bus.out_data), 64'h5555);
    chk("bp_release_valid", 64'(bus.out_valid), 64'h1);
    @(negedge clk);
    drive(0, 8'h00, 8'h00, 1);
    chk("bp_drain_rdy", 64'(bus.in_ready), 64'h00);
    tick();
    chk("bp_drain_valid", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    set_base_data();

    // Test 6: reset while locked on requester 5 (prio is 5 here)
    drive(0, 8'h20, 8'h00, 1);
    chk("rstlock_beat0_rdy", 64'(bus.in_ready), 64'h20);
    tick();
    @(negedge clk);
    drive(0, 8'h21, 8'h00, 1);
    chk("rstlock_beat1_rdy", 64'(bus.in_ready), 64'h20);
    tick();
    @(negedge clk);
    drive(1, 8'h21, 8'h21, 1);
    chk("rstlock_during_rdy", 64'(bus.in_ready), 64'h00);
    tick();
    chk("rstlock_during_valid", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    drive(0, 8'h21, 8'h21, 1);
    chk("rstlock_after_rdy", 64'(bus.in_ready), 64'h01);
    tick();
    chk("rstlock_after_src", 64'(bus.out_src), 64'h0);
    chk("rstlock_after_valid", 64'(bus.out_valid), 64'h1);
    @(negedge clk);

    // Randomized run against the behavioural model
    drive(1, 8'h00, 8'h00, 1);
    tick();
    @(negedge clk);
    m_prio = 0; m_owner = 0; m_locked = 0; m_ov = 0; m_src = 0; m_last = 0; m_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       r, o, free, xfer;
      logic [7:0] v, l, erdy;
      int         w, esel;
      logic [N-1:0] wdata;
      r = ($urandom_range(63) == 0);
      v = 8'($urandom) & 8'($urandom);
      l = 8'($urandom) | 8'($urandom);
      o = ($urandom_range(3) != 0);
      for (int i = 0; i < 8; i++) bus.in_data[i*N +: N] = $urandom;
      drive(r, v, l, o);
      w = mwin(v);
      esel = (w >= 0) ? w : (m_locked ? m_owner : m_prio);
      free = !m_ov || o;
      xfer = !r && (w >= 0) && free;
      erdy = xfer ? 8'(1 << w) : 8'h00;
      wdata = (w >= 0) ? bus.in_data[w*N +: N] : '0;
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(erdy));
      chk("rnd_sel", 64'(bus.sel), 64'(esel));
      tick();
      if (r) begin
        m_prio = 0; m_owner = 0; m_locked = 0; m_ov = 0; m_src = 0; m_last = 0; m_data = '0;
      end else if (xfer) begin
        m_ov = 1; m_data = wdata; m_src = w; m_last = l[w];
        if (l[w]) begin
          m_locked = 0;
          m_prio = (w + 1) % 8;
        end else begin
          m_locked = 1;
          m_owner = w;
        end
      end else if (free) begin
        m_ov = 0;
      end
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("rnd_out_data", 64'(bus.out_data), 64'(m_data));
        chk("rnd_out_src", 64'(bus.out_src), 64'(m_src));
        chk("rnd_out_last", 64'(bus.out_last), 64'(m_last));
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
